// File: rtl/alu_sequencer.sv
// alu_sequencer: execute-stage controller for a 16-bit combinational ALU.
// Accepts ADD/SUB/INC/MUL/CMP requests, drives the ALU from registered state,
// runs a 16-iteration shift-add multiply through the ALU ADD path, and returns
// result plus flags over a valid/ready response handshake.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_z,
    output logic        rsp_ovf,
    output logic        rsp_err,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    output logic [1:0]  alu_sel,
    input  logic [15:0] alu_out,
    input  logic        alu_z,
    input  logic        alu_ovf
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_CMP = 3'b100;

    localparam logic [1:0] SEL_ADD = 2'b00;
    localparam logic [1:0] SEL_SUB = 2'b01;
    localparam logic [1:0] SEL_INC = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Latched request; during a multiply r_a is the shifting multiplicand
    // and r_b the shifting multiplier.
    logic [2:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_acc;
    logic [3:0]  r_cnt;
    logic        r_lost;
    logic        r_ovf_s;

    logic [15:0] r_rsp_data;
    logic        r_rsp_z;
    logic        r_rsp_ovf;
    logic        r_rsp_err;

    logic [15:0] w_alu_in1;
    logic [15:0] w_alu_in2;
    logic [1:0]  w_alu_sel;

    logic        w_mul_add;
    logic        w_mul_last;
    logic [15:0] w_acc_next;
    logic        w_ovf_next;

    // A multiply iteration adds only when the current multiplier LSB is set.
    // Overflow accumulates when the add carries out, or when a set bit of the
    // multiplicand has already been shifted off the top (lost) and this
    // partial product would have needed it.
    assign w_mul_add  = (r_state == S_MUL) && r_b[0];
    assign w_mul_last = (r_cnt == 4'd15);
    assign w_acc_next = w_mul_add ? alu_out : r_acc;
    assign w_ovf_next = r_ovf_s | (w_mul_add & (alu_ovf | r_lost));

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_z     = r_rsp_z;
    assign rsp_ovf   = r_rsp_ovf;
    assign rsp_err   = r_rsp_err;
    assign alu_in1   = w_alu_in1;
    assign alu_in2   = w_alu_in2;
    assign alu_sel   = w_alu_sel;

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and ALU drive from registered state only.
    always_comb begin
        w_state_next = r_state;
        w_alu_in1    = 16'h0000;
        w_alu_in2    = 16'h0000;
        w_alu_sel    = SEL_ADD;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_next = (req_op == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_next = S_RESP;
                case (r_op)
                    OP_ADD: begin
                        w_alu_in1 = r_a;
                        w_alu_in2 = r_b;
                        w_alu_sel = SEL_ADD;
                    end
                    OP_SUB, OP_CMP: begin
                        w_alu_in1 = r_a;
                        w_alu_in2 = r_b;
                        w_alu_sel = SEL_SUB;
                    end
                    OP_INC: begin
                        w_alu_in1 = r_a;
                        w_alu_sel = SEL_INC;
                    end
                    default: begin
                        // Reserved opcodes leave the ALU at its idle value.
                    end
                endcase
            end
            S_MUL: begin
                if (r_b[0]) begin
                    w_alu_in1 = r_acc;
                    w_alu_in2 = r_a;
                    w_alu_sel = SEL_ADD;
                end
                if (w_mul_last) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, multiply iteration and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= 3'b000;
            r_a        <= 16'h0000;
            r_b        <= 16'h0000;
            r_acc      <= 16'h0000;
            r_cnt      <= 4'd0;
            r_lost     <= 1'b0;
            r_ovf_s    <= 1'b0;
            r_rsp_data <= 16'h0000;
            r_rsp_z    <= 1'b0;
            r_rsp_ovf  <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_a     <= req_a;
                        r_b     <= req_b;
                        r_acc   <= 16'h0000;
                        r_cnt   <= 4'd0;
                        r_lost  <= 1'b0;
                        r_ovf_s <= 1'b0;
                    end
                end
                S_EXEC: begin
                    case (r_op)
                        OP_ADD, OP_SUB, OP_INC: begin
                            r_rsp_data <= alu_out;
                            r_rsp_z    <= alu_z;
                            r_rsp_ovf  <= alu_ovf;
                            r_rsp_err  <= 1'b0;
                        end
                        OP_CMP: begin
                            r_rsp_data <= r_a;
                            r_rsp_z    <= alu_z;
                            r_rsp_ovf  <= alu_ovf;
                            r_rsp_err  <= 1'b0;
                        end
                        default: begin
                            r_rsp_data <= 16'h0000;
                            r_rsp_z    <= 1'b0;
                            r_rsp_ovf  <= 1'b0;
                            r_rsp_err  <= 1'b1;
                        end
                    endcase
                end
                S_MUL: begin
                    r_acc   <= w_acc_next;
                    r_ovf_s <= w_ovf_next;
                    r_lost  <= r_lost | r_a[15];
                    r_a     <= {r_a[14:0], 1'b0};
                    r_b     <= {1'b0, r_b[15:1]};
                    r_cnt   <= r_cnt + 4'd1;
                    if (w_mul_last) begin
                        r_rsp_data <= w_acc_next;
                        r_rsp_z    <= (w_acc_next == 16'h0000);
                        r_rsp_ovf  <= w_ovf_next;
                        r_rsp_err  <= 1'b0;
                    end
                end
                default: begin
                    // RESP holds the response registers stable.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: behavioural ALU, table of operations with a
// response scoreboard, plus backpressure and mid-multiply reset sequences.
module tb_alu_sequencer;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_CMP = 3'b100;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] data;
        logic        z;
        logic        ovf;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic        z;
        logic        ovf;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_z;
    logic        rsp_ovf;
    logic        rsp_err;
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    logic [1:0]  alu_sel;
    logic [15:0] alu_out;
    logic        alu_z;
    logic        alu_ovf;
    logic [16:0] alu_full;

    int   checks;
    int   errors;
    logic sel11_seen;
    rsp_t sb_q[$];
    vec_t vecs[16];

    alu_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_z     (rsp_z),
        .rsp_ovf   (rsp_ovf),
        .rsp_err   (rsp_err),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_z     (alu_z),
        .alu_ovf   (alu_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational ALU: 17-bit result, bit 16 is carry/borrow.
    always_comb begin
        case (alu_sel)
            2'b00:   alu_full = {1'b0, alu_in1} + {1'b0, alu_in2};
            2'b01:   alu_full = {1'b0, alu_in1} - {1'b0, alu_in2};
            2'b10:   alu_full = {1'b0, alu_in1} + 17'd1;
            default: alu_full = 17'd0;
        endcase
    end
    assign alu_out = alu_full[15:0];
    assign alu_z   = (alu_full[15:0] == 16'h0000);
    assign alu_ovf = alu_full[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected ALU drive in the first cycle after a request is accepted.
    function automatic logic [33:0] exp_alu(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        case (op)
            OP_ADD:         return {a, b, 2'b00};
            OP_SUB, OP_CMP: return {a, b, 2'b01};
            OP_INC:         return {a, 16'h0000, 2'b10};
            OP_MUL:         return b[0] ? {16'h0000, a, 2'b00} : 34'd0;
            default:        return 34'd0;
        endcase
    endfunction

    // Scoreboard: compare each retiring response against the queue head.
    always @(negedge clk) begin
        if (alu_sel == 2'b11) sel11_seen = 1'b1;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%0h required=none", rsp_data);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                check("sb_response", 64'({rsp_data, rsp_z, rsp_ovf, rsp_err}),
                      64'({e.data, e.z, e.ovf, e.err}));
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic run_op(input vec_t v);
        int n;
        check("req_ready_idle", 64'(req_ready), 64'(1'b1));
        sb_q.push_back('{v.data, v.z, v.ovf, v.err});
        req_valid = 1'b1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = OP_MUL;
        req_a     = 16'hDEAD;
        req_b     = 16'hBEEF;
        check("alu_drive_first", 64'({alu_in1, alu_in2, alu_sel}), 64'(exp_alu(v.op, v.a, v.b)));
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 64'(n), 64'(v.lat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        checks     = 0;
        errors     = 0;
        sel11_seen = 1'b0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 3'b000;
        req_a      = 16'h0000;
        req_b      = 16'h0000;
        rsp_ready  = 1'b1;

        vecs[0]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 2};
        vecs[1]  = '{OP_SUB, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b1, 1'b0, 2};
        vecs[2]  = '{OP_CMP, 16'h1234, 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 2};
        vecs[3]  = '{OP_MUL, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0, 1'b0, 17};
        vecs[4]  = '{OP_MUL, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, 17};
        vecs[5]  = '{OP_MUL, 16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b0, 17};
        vecs[6]  = '{OP_INC, 16'h7FFF, 16'h1234, 16'h8000, 1'b0, 1'b0, 1'b0, 2};
        vecs[7]  = '{OP_INC, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 2};
        vecs[8]  = '{OP_ADD, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0, 2};
        vecs[9]  = '{OP_CMP, 16'h0001, 16'h0002, 16'h0001, 1'b0, 1'b1, 1'b0, 2};
        vecs[10] = '{3'b111, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b1, 2};
        vecs[11] = '{3'b101, 16'h0F0F, 16'h0101, 16'h0000, 1'b0, 1'b0, 1'b1, 2};
        vecs[12] = '{OP_MUL, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 1'b0, 17};
        vecs[13] = '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 17};
        vecs[14] = '{OP_MUL, 16'h0000, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 17};
        vecs[15] = '{OP_SUB, 16'h0007, 16'h0005, 16'h0002, 1'b0, 1'b0, 1'b0, 2};

        // Reset state while rst_n is held low.
        repeat (3) @(negedge clk);
        check("reset_state",
              64'({rsp_valid, req_ready, rsp_data, rsp_z, rsp_ovf, rsp_err, alu_in1, alu_in2, alu_sel}),
              64'({1'b0, 1'b1, 16'h0000, 3'b000, 16'h0000, 16'h0000, 2'b00}));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i]);
        end

        // Backpressure: response held for 5 cycles, request pulse ignored.
        rsp_ready = 1'b0;
        sb_q.push_back('{16'h3333, 1'b0, 1'b0, 1'b0});
        req_valid = 1'b1;
        req_op    = OP_ADD;
        req_a     = 16'h1111;
        req_b     = 16'h2222;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_latency", 64'(n), 64'(2));
        for (int k = 0; k < 5; k++) begin
            check("bp_hold", 64'({rsp_valid, req_ready, rsp_data, rsp_z, rsp_ovf, rsp_err}),
                  64'({1'b1, 1'b0, 16'h3333, 3'b000}));
            if (k == 2) begin
                req_valid = 1'b1;
                req_op    = OP_ADD;
                req_a     = 16'h0001;
                req_b     = 16'h0001;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        check("bp_no_extra_rsp", 64'(n), 64'(0));
        check("bp_ready_after", 64'(req_ready), 64'(1'b1));

        // Reset during MUL iteration 8: outputs return to reset values at once.
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op    = OP_MUL;
        req_a     = 16'hFFFF;
        req_b     = 16'hFFFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        check("mul_active_before_rst", 64'(alu_in2 != 16'h0000), 64'(1'b1));
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs",
              64'({rsp_valid, req_ready, rsp_data, rsp_z, rsp_ovf, rsp_err, alu_in1, alu_in2, alu_sel}),
              64'({1'b0, 1'b1, 16'h0000, 3'b000, 16'h0000, 16'h0000, 2'b00}));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (25) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        check("rst_no_resp", 64'(n), 64'(0));

        // Normal operation resumes after the abandoned multiply.
        @(posedge clk);
        #1;
        run_op(vecs[13]);

        @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'(0));
        check("alu_sel_never_11", 64'(sel11_seen), 64'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Execute-stage controller that drives the 16-bit combinational ALU from the ALU's input side. It accepts operation requests over a valid/ready handshake and drives alu_in1/alu_in2/alu_sel. It captures alu_out/z/ovf, runs a 16-iteration shift-add multiply through the ALU's ADD path, and returns result and flags over a second valid/ready handshake to writeback.

## Interface
- No parameters; all datapaths are 16 bits, matching the ALU.
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_op  in  3  000 ADD, 001 SUB, 010 INC, 011 MUL, 100 CMP, others reserved
- req_a  in  16  operand A
- req_b  in  16  operand B (ignored for INC)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  16  result
- rsp_z  out  1  zero flag
- rsp_ovf  out  1  carry/borrow/overflow flag
- rsp_err  out  1  reserved opcode
- alu_in1  out  16  to ALU
- alu_in2  out  16  to ALU
- alu_sel  out  2  to ALU: 00 add, 01 sub, 10 increment; 11 is never driven
- alu_out  in  16  from ALU
- alu_z  in  1  from ALU
- alu_ovf  in  1  from ALU; bit 16 of the 17-bit result (carry on add, borrow on sub)

## Operation
- States: IDLE, EXEC, MUL_LOOP, RESP. Reset enters IDLE.
- **IDLE:** req_ready=1. On req_valid, latch op, a and b.
  - MUL goes to MUL_LOOP with acc=0, mcand=a, mplier=b, cnt=0, lost=0, ovf_s=0.
  - All other opcodes, including reserved ones, go to EXEC.
- **EXEC:** drives the ALU from the latched operands and registers the response at the end of the cycle, then goes to RESP.
  - ADD: sel 00, in1=a, in2=b.
  - SUB: sel 01, in1=a, in2=b.
  - INC: sel 10, in1=a, in2=0.
  - CMP: sel 01, in1=a, in2=b. rsp_data=a. rsp_z and rsp_ovf are taken from the ALU, so rsp_ovf=1 iff a<b unsigned.
  - Non-CMP ops: rsp_data=alu_out, rsp_z=alu_z, rsp_ovf=alu_ovf.
  - Reserved opcodes: the ALU is not used. rsp_data=0, rsp_z=0, rsp_ovf=0, rsp_err=1.
- **MUL_LOOP:** one iteration per cycle, 16 iterations exactly; there is no early exit.
  - If mplier[0]=1: drive sel 00, in1=acc, in2=mcand; acc<=alu_out; ovf_s|=alu_ovf|lost.
  - If mplier[0]=0: ALU inputs are at the idle value and acc holds.
  - Every cycle: lost|=mcand[15]; mcand<<=1; mplier>>=1; cnt++.
  - After cnt=15: rsp_data=final acc, rsp_z=(final acc==0), rsp_ovf=ovf_s, rsp_err=0, then RESP.
  - rsp_ovf is therefore 1 iff the unsigned product is at least 2^16.
- **RESP:** rsp_valid=1. rsp_* stay stable until rsp_ready=1, then go to IDLE. A new request is never accepted in the same cycle as response retirement.
- **ALU idle value:** in IDLE and RESP, and for skipped MUL iterations, alu_in1=0, alu_in2=0, alu_sel=00.
- ALU drive is combinational from registered state only, never from req_* inputs.
- All state, operand registers and rsp_* are flops. req_ready and rsp_valid decode directly from state.

## Timing
- **Reset values:** rsp_valid=0, rsp_data=0, rsp_z=0, rsp_ovf=0, rsp_err=0, alu_in1=0, alu_in2=0, alu_sel=00. req_ready=1 (IDLE), including while rst_n is low.
- **Reset mid-operation:** the operation is abandoned immediately. No response is produced and the latched operands are cleared.
- **Latency** (request accepted at edge 0):
  - Single-cycle ops and reserved opcodes: rsp_valid high after edge 2.
  - MUL: rsp_valid high after edge 17.
- **Throughput:** at most one op per 3 cycles (single-cycle ops) or per 18 cycles (MUL) with rsp_ready tied high.
- **Backpressure:** if rsp_ready is low, RESP holds indefinitely and req_ready stays 0.
- req_* inputs are sampled only at the IDLE accepting edge; later changes have no effect.

## Test plan
- ADD a=0xFFFF, b=0x0001 -> rsp_data=0x0000, z=1, ovf=1, err=0; rsp_valid 2 cycles after accept.
- SUB a=0x0005, b=0x0007 -> rsp_data=0xFFFE, z=0, ovf=1. CMP a=0x1234, b=0x1234 -> rsp_data=0x1234, z=1, ovf=0.
- MUL 0x00FF*0x0101 -> 0xFFFF, z=0, ovf=0 at 17 cycles. MUL 0x0100*0x0100 -> 0x0000, z=1, ovf=1. MUL 0x8000*0x0001 -> 0x8000, ovf=0. alu_sel must never be 11.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid. rsp_* must stay constant, req_ready=0 throughout, and a req_valid pulse meanwhile must be ignored.
- Reset: assert rst_n=0 at MUL loop iteration 8 -> all outputs at reset values at once, and no response after release.
- Reserved op 3'b111, a=0xAAAA -> rsp_err=1, rsp_data=0x0000, z=0, ovf=0, and the ALU inputs stay at the idle value.
